// File: rtl/sdram_arb_n.sv
// N-channel arbiter in front of a single SDRAM command port: ch0 priority with a starvation
// bound, round-robin among the rest, staged write bursts and in-order routing of read beats.
module sdram_arb_n #(
    parameter int NCH        = 3,
    parameter int AW         = 23,
    parameter int DW         = 32,
    parameter int LW         = 4,
    parameter int RTAG_DEPTH = 4,
    parameter int HP_MAX     = 4
) (
    input  logic                  sdramclk_i,
    input  logic                  rst_sdramclk_i,
    input  logic [NCH-1:0]        cmd_i,
    input  logic [NCH-1:0]        cmd_en_i,
    input  logic [NCH*AW-1:0]     addr_i,
    input  logic [NCH*LW-1:0]     len_i,
    input  logic [NCH*DW-1:0]     wdata_i,
    input  logic [NCH*DW/8-1:0]   mask_i,
    output logic [NCH-1:0]        cmd_ready_o,
    output logic [DW-1:0]         rdata_o,
    output logic [NCH-1:0]        rvalid_o,
    output logic                  sdram_cmd_o,
    output logic                  sdram_cmd_en_o,
    output logic [AW-1:0]         sdram_addr_o,
    output logic [LW-1:0]         sdram_cmd_len_o,
    input  logic                  sdram_ack_i,
    output logic [DW-1:0]         sdram_wdata_o,
    output logic [DW/8-1:0]       sdram_mask_o,
    input  logic [DW-1:0]         sdram_rdata_i,
    input  logic                  sdram_rvalid_i
);
    localparam int MW     = DW / 8;
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW     = (RTAG_DEPTH > 1) ? $clog2(RTAG_DEPTH) : 1;
    localparam int SW     = (HP_MAX > 0) ? $clog2(HP_MAX + 1) : 1;
    localparam int WDEPTH = 1 << LW;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DONE, WR_FILL, WR_WAIT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q;
    logic [CW-1:0]   rrPtr_q, rrPtr_d;
    logic [SW-1:0]   starveCnt_q, starveCnt_d;
    logic [LW-1:0]   wpt_q, rpt_q;
    logic            draining_q, acked_q;

    logic [NCH-1:0]  elig;
    logic            otherElig, pick0, rrFound, grant, ackNow;
    logic [CW-1:0]   rrWin, winner;
    int              idx;

    logic [DW+MW-1:0] wfifo [WDEPTH];

    logic [CW-1:0]   tagCh  [RTAG_DEPTH];
    logic [LW-1:0]   tagLen [RTAG_DEPTH];
    logic [TW-1:0]   tagWr_q, tagRd_q;
    logic [TW:0]     tagCnt_q;
    logic [LW-1:0]   beatCnt_q;
    logic            tagFull, tagEmpty, tagPush, tagPop;

    assign tagFull  = (tagCnt_q == (TW+1)'(RTAG_DEPTH));
    assign tagEmpty = (tagCnt_q == '0);
    assign tagPush  = ackNow && (state_q == RD_REQ);
    assign tagPop   = sdram_rvalid_i && !tagEmpty && (beatCnt_q == tagLen[tagRd_q]);

    assign {sdram_wdata_o, sdram_mask_o} = wfifo[rpt_q];

    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++)
            elig[i] = cmd_en_i[i] && (cmd_i[i] || !tagFull);
        otherElig = |elig[NCH-1:1];

        // Round-robin search begins just past the last non-ch0 winner, wrapping within 1..NCH-1.
        rrFound = 1'b0;
        rrWin   = '0;
        idx     = 0;
        for (int k = 1; k < NCH; k++) begin
            idx = ((int'(rrPtr_q) - 1 + k) % (NCH - 1)) + 1;
            if (!rrFound && elig[idx]) begin
                rrFound = 1'b1;
                rrWin   = CW'(idx);
            end
        end

        pick0  = elig[0] && !((HP_MAX != 0) && (starveCnt_q == SW'(HP_MAX)) && otherElig);
        grant  = (state_q == IDLE) && !draining_q && (pick0 || rrFound);
        winner = pick0 ? '0 : rrWin;

        sdram_cmd_en_o = (state_q == RD_REQ) || (state_q == WR_WAIT) ||
                         ((state_q == WR_FILL) && (wpt_q != '0) && !acked_q);
        ackNow = sdram_ack_i && sdram_cmd_en_o;

        cmd_ready_o = '0;
        if ((state_q == RD_DONE) || ((state_q == WR_FILL) && (wpt_q == '0)))
            cmd_ready_o[ch_q] = 1'b1;

        starveCnt_d = starveCnt_q;
        rrPtr_d     = rrPtr_q;
        if (grant) begin
            if (pick0) begin
                if (!otherElig)
                    starveCnt_d = '0;
                else if (starveCnt_q != SW'(HP_MAX))
                    starveCnt_d = starveCnt_q + 1'b1;
            end else begin
                starveCnt_d = '0;
                rrPtr_d     = rrWin;
            end
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = cmd_i[winner] ? WR_FILL : RD_REQ;
            RD_REQ:  if (ackNow) state_d = RD_DONE;
            RD_DONE: state_d = IDLE;
            WR_FILL: if (wpt_q == sdram_cmd_len_o) state_d = (acked_q || ackNow) ? IDLE : WR_WAIT;
            WR_WAIT: if (ackNow) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sdramclk_i) begin
        if (rst_sdramclk_i) begin
            state_q         <= IDLE;
            ch_q            <= '0;
            rrPtr_q         <= CW'(NCH - 1);
            starveCnt_q     <= '0;
            sdram_cmd_o     <= 1'b0;
            sdram_addr_o    <= '0;
            sdram_cmd_len_o <= '0;
            wpt_q           <= '0;
            rpt_q           <= '0;
            draining_q      <= 1'b0;
            acked_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            rrPtr_q     <= rrPtr_d;
            starveCnt_q <= starveCnt_d;
            if (grant) begin
                ch_q            <= winner;
                sdram_cmd_o     <= cmd_i[winner];
                sdram_addr_o    <= addr_i[int'(winner)*AW +: AW];
                sdram_cmd_len_o <= len_i[int'(winner)*LW +: LW];
            end
            if (state_q == WR_FILL) begin
                wpt_q <= (wpt_q == sdram_cmd_len_o) ? '0 : wpt_q + 1'b1;
                if (wpt_q == sdram_cmd_len_o)
                    acked_q <= 1'b0;
                else if (ackNow)
                    acked_q <= 1'b1;
            end
            // Drain pointer sits at beat 0 during the ack cycle, then walks one beat per cycle.
            if (ackNow && sdram_cmd_o) begin
                if (sdram_cmd_len_o != '0) begin
                    draining_q <= 1'b1;
                    rpt_q      <= LW'(1);
                end
            end else if (draining_q) begin
                if (rpt_q == sdram_cmd_len_o) begin
                    draining_q <= 1'b0;
                    rpt_q      <= '0;
                end else begin
                    rpt_q <= rpt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sdramclk_i) begin
        if (state_q == WR_FILL)
            wfifo[wpt_q] <= {wdata_i[int'(ch_q)*DW +: DW], mask_i[int'(ch_q)*MW +: MW]};
        if (tagPush) begin
            tagCh[tagWr_q]  <= ch_q;
            tagLen[tagWr_q] <= sdram_cmd_len_o;
        end
    end

    always_ff @(posedge sdramclk_i) begin
        if (rst_sdramclk_i) begin
            tagWr_q   <= '0;
            tagRd_q   <= '0;
            tagCnt_q  <= '0;
            beatCnt_q <= '0;
            rvalid_o  <= '0;
            rdata_o   <= '0;
        end else begin
            if (tagPush) tagWr_q <= tagWr_q + 1'b1;
            if (tagPop)  tagRd_q <= tagRd_q + 1'b1;
            if (tagPush && !tagPop)
                tagCnt_q <= tagCnt_q + 1'b1;
            else if (!tagPush && tagPop)
                tagCnt_q <= tagCnt_q - 1'b1;
            rvalid_o <= '0;
            if (sdram_rvalid_i) begin
                rdata_o <= sdram_rdata_i;
                if (!tagEmpty) begin
                    rvalid_o[tagCh[tagRd_q]] <= 1'b1;
                    beatCnt_q <= tagPop ? '0 : beatCnt_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/sdram_arb_n.md
# sdram_arb_n

- Parametrised N-channel arbiter between SDRAM client masters and the single SDRAM controller command port, in the `sdramclk` domain.
- Channel 0 has strict priority, bounded by a starvation limit. Channels 1..NCH-1 share grants round-robin.
- Write bursts are staged in an internal FIFO.
- Up to RTAG_DEPTH read commands may be outstanding; returning beats are routed to the issuing channel in order.

## Interface
- NCH, 3: channel count, ≥2.
- AW, 23: address width.
- DW, 32: data width, multiple of 8.
- LW, 4: burst length field width. len = beats−1. Write FIFO depth is 2^LW.
- RTAG_DEPTH, 4: maximum outstanding read commands, power of 2.
- HP_MAX, 4: consecutive ch0 grants allowed while another channel is eligible. 0 = pure strict priority.
- sdramclk  in  1  clock.
- rst_sdramclk  in  1  reset. One clock; reset is synchronous and active-high.
- cmd  in  NCH  per channel: 0 = read, 1 = write.
- cmd_en  in  NCH  request. Held until that channel's cmd_ready pulse.
- addr  in  NCH*AW  per-channel address, channel i at [i*AW +: AW].
- len  in  NCH*LW  per-channel beats−1.
- wdata  in  NCH*DW  per-channel write beat.
- mask  in  NCH*DW/8  per-channel byte mask.
- cmd_ready  out  NCH  one-cycle accept pulse.
- rdata  out  DW  read beat, shared by all channels.
- rvalid  out  NCH  per-channel read beat strobe.
- sdram_cmd  out  1  command to the controller.
- sdram_cmd_en  out  1  command request to the controller.
- sdram_addr  out  AW  command address.
- sdram_cmd_len  out  LW  command length (beats−1).
- sdram_ack  in  1  controller accepts the command.
- sdram_wdata  out  DW  write beat to the controller.
- sdram_mask  out  DW/8  write byte mask to the controller.
- sdram_rdata  in  DW  read beat from the controller.
- sdram_rvalid  in  1  read beat valid from the controller.

## Operation
- Eligibility: channel i is eligible when cmd_en[i] is high and either cmd[i]=1 or the tag FIFO is not full.
- Arbitration is evaluated only in IDLE, and only when the drain is inactive:
  - Ch0 wins if eligible, unless starve_cnt==HP_MAX (with HP_MAX≠0) and some channel 1..NCH-1 is eligible.
  - Otherwise the round-robin winner wins: search starts at rr_ptr+1 and wraps within 1..NCH-1.
- Counters and pointers on grant:
  - starve_cnt increments on a ch0 grant while another channel is eligible.
  - starve_cnt clears on any non-ch0 grant, and when no other channel is eligible.
  - rr_ptr updates to the winner on a non-ch0 grant.
- On grant, the winning channel's cmd, addr and len are registered into sdram_cmd, sdram_addr and sdram_cmd_len. Capture into these registers happens only at grant.
- States:
  - IDLE: on grant, go to RD_REQ for a read or WR_FILL for a write.
  - RD_REQ: sdram_cmd_en=1. On sdram_ack, push {ch, len} into the tag FIFO and go to RD_DONE.
  - RD_DONE: cmd_ready[ch] pulses. Go to IDLE.
  - WR_FILL: write wdata/mask of ch into wfifo[wpt] each cycle.
    - cmd_ready[ch] pulses in the first WR_FILL cycle.
    - sdram_cmd_en rises from the second fill cycle.
    - Exit when wpt==len: go to IDLE if already acked, else WR_WAIT.
  - WR_WAIT: sdram_cmd_en=1. On sdram_ack, go to IDLE.
- Write drain:
  - sdram_wdata/sdram_mask = wfifo[rpt], combinational.
  - rpt=0 in the ack cycle, then increments every cycle until it reaches len, then returns to 0.
  - Beat k is therefore valid at ack+k.
- Read return:
  - rdata is sdram_rdata registered on sdram_rvalid.
  - rvalid[head.ch] is sdram_rvalid delayed by one cycle.
  - A beat counter pops the tag FIFO after head.len+1 beats.
  - Beats arriving with the tag FIFO empty are dropped; rvalid stays 0.
- Master write rule: beat k must be presented at (cmd_ready cycle + k).

## Timing
- Reset values:
  - Outputs cmd_ready, rvalid, sdram_cmd_en, sdram_cmd, sdram_addr and sdram_cmd_len are 0.
  - Internal: state=IDLE, rr_ptr=NCH−1, starve_cnt=0, wpt=rpt=0, tag FIFO empty.
- Reset mid-burst abandons the burst: FIFO contents become don't-care, and no pulses occur on the first cycle after reset.
- Read latency:
  - grant edge → sdram_cmd_en high next cycle.
  - ack → cmd_ready one cycle later.
- Write latency:
  - grant → cmd_ready next cycle.
  - sdram_cmd_en one cycle after that.
  - IDLE re-entry no earlier than len+1 cycles after cmd_ready.
- Ack handling:
  - sdram_cmd_en falls the cycle after sdram_ack.
  - An ack arriving during WR_FILL is honoured.
  - Ack and the last fill beat arriving in the same cycle → IDLE.
- Tag FIFO:
  - Push and pop in the same cycle is legal and leaves the count unchanged.
  - When full, read requests are masked while writes still arbitrate.
- Minimum IDLE→IDLE interval is 3 cycles for a read and len+2 cycles for a write.

## Test plan
- NCH=3, all reset values checked. Ch1 reads addr 0x100 with len 3; controller acks 2 cycles after sdram_cmd_en and returns 4 beats → cmd_ready[1] pulses once; rvalid[1] is high 4 cycles; rdata matches; rvalid[0] and rvalid[2] stay 0.
- Ch2 writes len 7 with beats 0xA0..0xA7; ack is given in the 3rd fill cycle → sdram_wdata shows 0xA0..0xA7 at ack+0..ack+7; masks match.
- Ch1 and ch2 request continuously, ch0 idle → grants alternate 1,2,1,2.
- Ch0 and ch1 request continuously with HP_MAX=4 → grant pattern 0,0,0,0,1 repeating.
- Four reads issued, rvalid withheld → 5th read is not granted while a pending ch2 write is granted. The first beats then return to the correct channels in issue order.
- Reset asserted mid-WR_FILL → next cycle all outputs are 0 and state=IDLE; a subsequent read completes normally.
